// File: rtl/sample_buffer_reader.sv
// Read-side controller for a distributed-RAM sample buffer: owns the read pointer,
// registers RAM words into a valid/ready stream, and tracks occupancy and overflow.
module sample_buffer_reader #(
  parameter int DW       = 14,
  parameter int AW       = 6,
  parameter int AF_LEVEL = 48
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CLR,
  input  logic          WINC,
  output logic [AW-1:0] RA,
  input  logic [DW-1:0] RD,
  output logic [DW-1:0] DOUT,
  output logic          DVAL,
  input  logic          DRDY,
  output logic [AW:0]   CNT,
  output logic          EMPTY,
  output logic          AFULL,
  output logic          OVF
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
  localparam logic [AW:0] AF_TH = (AW+1)'(AF_LEVEL);

  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dval_q, dval_d;
  logic          ovf_q, ovf_d;
  logic          load;
  logic          full;

  always_comb begin
    load   = (cnt_q != '0) && (!dval_q || DRDY);
    full   = (cnt_q == DEPTH);
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    dval_d = dval_q;
    ovf_d  = ovf_q;

    if (load) begin
      dout_d = RD;
      dval_d = 1'b1;
      rp_d   = rp_q + AW'(1);
    end else if (DRDY) begin
      dval_d = 1'b0;
    end

    // A write into a full buffer with nothing leaving has clobbered unread data.
    if (WINC && !load) begin
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!WINC && load) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rp_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      dval_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (CLR) begin
      rp_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      dval_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      dval_q <= dval_d;
      ovf_q  <= ovf_d;
    end
  end

  assign RA    = rp_q;
  assign DOUT  = dout_q;
  assign DVAL  = dval_q;
  assign CNT   = cnt_q;
  assign OVF   = ovf_q;
  assign EMPTY = (cnt_q == '0);
  assign AFULL = (cnt_q >= AF_TH);

endmodule

// File: tb/tb_sample_buffer_reader.sv
// Bench for sample_buffer_reader: models the writer and RAM, checks a vector table,
// multi-cycle corner sequences, and FIFO order through a scoreboard queue.
module tb_sample_buffer_reader;
  localparam int DW = 14;
  localparam int AW = 6;
  localparam int AF = 48;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          CLR = 1'b0;
  logic          WINC = 1'b0;
  logic          DRDY = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] RA;
  logic [DW-1:0] RD;
  logic [DW-1:0] DOUT;
  logic          DVAL;
  logic [AW:0]   CNT;
  logic          EMPTY;
  logic          AFULL;
  logic          OVF;

  logic [DW-1:0] mem [64];
  logic [AW-1:0] wp;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_en   = 1'b1;
  logic [DW-1:0] expq [$];

  sample_buffer_reader #(.DW(DW), .AW(AW), .AF_LEVEL(AF)) dut (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .WINC(WINC), .RA(RA), .RD(RD),
    .DOUT(DOUT), .DVAL(DVAL), .DRDY(DRDY), .CNT(CNT), .EMPTY(EMPTY),
    .AFULL(AFULL), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Writer side and asynchronous-read RAM
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  assign RD = mem[RA];
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN)     wp <= '0;
    else if (CLR)  wp <= '0;
    else if (WINC) begin
      mem[wp] <= wdata;
      wp      <= wp + 6'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a word is consumed when DVAL and DRDY are both high before the edge
  always @(negedge CLK) begin
    if (sb_en && RSTN && DVAL && DRDY) begin
      n_tests++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got %0h expected none", DOUT);
      end else begin
        logic [DW-1:0] e;
        e = expq.pop_front();
        if (DOUT !== e) begin
          n_fail++;
          $display("FAIL sb_data: got %0h expected %0h at %0t", DOUT, e, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit w, input logic [DW-1:0] d, input bit r);
    WINC  = w;
    wdata = d;
    DRDY  = r;
    if (w && sb_en) expq.push_back(d);
  endtask

  task automatic do_clr();
    drive(1'b0, '0, 1'b0);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    expq.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ra"},    32'(RA),    32'd0);
    chk({tag, "_cnt"},   32'(CNT),   32'd0);
    chk({tag, "_empty"}, 32'(EMPTY), 32'd1);
    chk({tag, "_afull"}, 32'(AFULL), 32'd0);
    chk({tag, "_dval"},  32'(DVAL),  32'd0);
    chk({tag, "_dout"},  32'(DOUT),  32'd0);
    chk({tag, "_ovf"},   32'(OVF),   32'd0);
  endtask

  typedef struct {
    bit            winc;
    logic [DW-1:0] wd;
    bit            drdy;
    logic [AW:0]   cnt;
    bit            dval;
    logic [DW-1:0] dout;
    logic [AW-1:0] ra;
    bit            empty;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // single word, then three words under backpressure
    tbl[0] = '{1'b1, 14'h1ABC, 1'b1, 7'd1, 1'b0, 14'h0000, 6'd0, 1'b0};
    tbl[1] = '{1'b0, 14'h0000, 1'b1, 7'd0, 1'b1, 14'h1ABC, 6'd1, 1'b1};
    tbl[2] = '{1'b0, 14'h0000, 1'b1, 7'd0, 1'b0, 14'h1ABC, 6'd1, 1'b1};
    tbl[3] = '{1'b1, 14'h0001, 1'b0, 7'd1, 1'b0, 14'h1ABC, 6'd1, 1'b0};
    tbl[4] = '{1'b1, 14'h0002, 1'b0, 7'd1, 1'b1, 14'h0001, 6'd2, 1'b0};
    tbl[5] = '{1'b1, 14'h0003, 1'b0, 7'd2, 1'b1, 14'h0001, 6'd2, 1'b0};
    tbl[6] = '{1'b0, 14'h0000, 1'b0, 7'd2, 1'b1, 14'h0001, 6'd2, 1'b0};
    tbl[7] = '{1'b0, 14'h0000, 1'b1, 7'd1, 1'b1, 14'h0002, 6'd3, 1'b0};
    tbl[8] = '{1'b0, 14'h0000, 1'b1, 7'd0, 1'b1, 14'h0003, 6'd4, 1'b1};
    tbl[9] = '{1'b0, 14'h0000, 1'b1, 7'd0, 1'b0, 14'h0003, 6'd4, 1'b1};

    // Reset and idle
    #2;
    chk_idle("in_reset");
    repeat (3) tick();
    RSTN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("idle");
    end

    // Vector table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].winc, tbl[i].wd, tbl[i].drdy);
      tick();
      chk($sformatf("v%0d_cnt", i),   32'(CNT),   32'(tbl[i].cnt));
      chk($sformatf("v%0d_dval", i),  32'(DVAL),  32'(tbl[i].dval));
      chk($sformatf("v%0d_dout", i),  32'(DOUT),  32'(tbl[i].dout));
      chk($sformatf("v%0d_ra", i),    32'(RA),    32'(tbl[i].ra));
      chk($sformatf("v%0d_empty", i), 32'(EMPTY), 32'(tbl[i].empty));
    end

    // Wrap and AFULL: fill to the threshold, then stream at matched rate
    do_clr();
    chk_idle("clr1");
    for (int i = 0; i <= 48; i++) begin
      drive(1'b1, DW'(i), 1'b0);
      tick();
      chk("fill_cnt",   32'(CNT),   (i == 0) ? 32'd1 : 32'(i));
      chk("fill_afull", 32'(AFULL), (i >= 48) ? 32'd1 : 32'd0);
    end
    for (int i = 49; i < 70; i++) begin
      drive(1'b1, DW'(i), 1'b1);
      tick();
      chk("stream_cnt",   32'(CNT),   32'd48);
      chk("stream_afull", 32'(AFULL), 32'd1);
    end
    for (int j = 1; j <= 48; j++) begin
      drive(1'b0, '0, 1'b1);
      tick();
      chk("drain_cnt",   32'(CNT),   32'(48 - j));
      chk("drain_afull", 32'(AFULL), 32'd0);
    end
    tick();
    chk("wrap_dval",  32'(DVAL),  32'd0);
    chk("wrap_empty", 32'(EMPTY), 32'd1);
    chk("wrap_ra",    32'(RA),    32'd6);
    chk("wrap_ovf",   32'(OVF),   32'd0);
    chk("wrap_sb",    32'(expq.size()), 32'd0);

    // Overflow: writer keeps going with downstream stalled
    do_clr();
    sb_en = 1'b0;
    for (int i = 0; i <= 64; i++) begin
      drive(1'b1, DW'(i + 100), 1'b0);
      tick();
      if (i == 63) chk("ovf_cnt63", 32'(CNT), 32'd63);
    end
    chk("ovf_cnt64",   32'(CNT),   32'd64);
    chk("ovf_afull",   32'(AFULL), 32'd1);
    chk("ovf_early",   32'(OVF),   32'd0);
    drive(1'b1, 14'h0111, 1'b1);
    tick();
    chk("full_ld_cnt", 32'(CNT), 32'd64);
    chk("full_ld_ovf", 32'(OVF), 32'd0);
    chk("full_ld_ra",  32'(RA),  32'd2);
    drive(1'b1, 14'h0222, 1'b0);
    tick();
    chk("ovf_set",     32'(OVF), 32'd1);
    chk("ovf_cnt",     32'(CNT), 32'd64);
    chk("ovf_ra",      32'(RA),  32'd2);
    drive(1'b0, '0, 1'b0);
    tick();
    chk("ovf_sticky",  32'(OVF), 32'd1);
    do_clr();
    chk_idle("clr2");
    sb_en = 1'b1;

    // Async reset in the middle of a stream
    for (int i = 0; i <= 10; i++) begin
      drive(1'b1, DW'(200 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    chk("pre_rst_cnt",  32'(CNT),  32'd10);
    chk("pre_rst_dval", 32'(DVAL), 32'd1);
    #2;
    RSTN = 1'b0;
    #1;
    chk_idle("async_rst");
    expq.delete();
    tick();
    tick();
    RSTN = 1'b1;
    tick();
    chk_idle("post_rst");
    drive(1'b1, 14'h2AAA, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    chk("recover_dout", 32'(DOUT), 32'h2AAA);
    chk("recover_dval", 32'(DVAL), 32'd1);
    tick();
    chk("recover_sb",   32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
